ball_physics: RTL and testbench
===============================

Name: ball_physics

Overview:
- Game-state stage directly downstream of the collision detector.
- Consumes the registered paddle/block hit flags once per video frame and updates:
  - ball position and direction;
  - per-block alive mask, score, lives;
  - serve/play/game-over state.
- Ball position feeds back into the collision detector and the pixel renderer. The alive mask gates block drawing and hit acceptance.

Parameters:
- SCREEN_W, 640, playfield width in pixels.
- SCREEN_H, 480, playfield height in pixels.
- BALL_SIZE, 8, ball width/height in pixels.
- SPEED, 2, pixels moved per axis per frame.
- START_X, 316, ball x at serve.
- START_Y, 400, ball y at serve.
- NUM_BLOCKS, 10, blocks tracked (bit i = collide_block index i+1).
- START_LIVES, 3, lives after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame (end of active video)
- launch  in  1  level; starts ball from SERVE
- collide_paddle  in  1  registered paddle-overlap flag
- collide_block  in  NUM_BLOCKS  registered block-overlap flags, bit0 = first block
- paddle_x  in  10  paddle left edge; ball follows it while in SERVE
- ball_x  out  10  ball left edge
- ball_y  out  10  ball top edge
- block_alive  out  NUM_BLOCKS  1 = block present
- score  out  8  blocks destroyed, saturating at 255
- lives  out  2  remaining lives
- game_over  out  1  high in OVER or WIN
- ball_active  out  1  high in PLAY

Behaviour:
- Reset (rst low, async) forces:
  - state SERVE; ball_x = START_X; ball_y = START_Y;
  - dx = +1, dy = -1 (up-right);
  - block_alive all ones; score 0; lives START_LIVES; outputs as implied by state.
- All state changes happen only on cycles where frame_tick = 1. Inputs on other cycles are ignored. Outputs change one cycle after the tick, which is the registered update.
- States:
  - SERVE: ball_x = paddle_x + 28, ball_y = START_Y each tick. launch = 1 on a tick → PLAY. Direction is reset to up-right.
  - PLAY: movement and collision processing, in this priority order within one tick:
    - (a) Block hit: if (collide_block & block_alive) != 0, take the lowest set index k. Clear block_alive[k], score+1 (saturating), invert dy. Only one block is cleared per tick.
    - (b) Otherwise, paddle hit: if collide_paddle and dy = +1 (moving down), set dy = -1. A paddle flag while moving up is ignored, which prevents sticking.
    - (c) Walls are evaluated on the pre-move position:
      - ball_x ≤ SPEED → dx = +1.
      - ball_x + BALL_SIZE ≥ SCREEN_W - SPEED → dx = -1.
      - ball_y ≤ SPEED → dy = +1.
      - A wall reflection overrides the dy from (a)/(b) on the same axis.
    - (d) Move: ball_x += dx*SPEED and ball_y += dy*SPEED, using the new directions. 10-bit arithmetic; wall rules guarantee no wrap.
    - (e) Loss: if ball_y + BALL_SIZE ≥ SCREEN_H, go to LOST instead of moving.
    - (f) Win: if block_alive becomes all zero this tick → WIN.
  - LOST: next tick, lives-1. If the result is 0 → OVER; else → SERVE.
  - OVER / WIN: ball frozen, game_over = 1. Only reset exits.
- Collision flags are already one cycle latent relative to ball position. Because sampling is frame-rate, they are stable at the tick; no extra alignment is needed.
- Hits on dead blocks (alive = 0) are ignored, with no reflection.
- Simultaneous block and paddle flags: the block wins and the paddle flag is ignored that tick.
- Reset mid-frame or mid-PLAY: immediate return to the reset values above.

Decomposition:
- Shared package: state encoding (SERVE, PLAY, LOST, OVER, WIN), playfield constants, BALL_SIZE and START_* constants. The collision detector and renderer use the same constants.
- One sub-module: block_hit_select. It is combinational: a lowest-set-bit priority encoder over (collide_block & block_alive), outputting hit_valid and a one-hot clear mask.

Test Plan:
- Reset, then 3 ticks with launch = 0 and paddle_x = 300 → ball_x = 328, ball_y = 400, ball_active = 0, block_alive = 0x3FF, lives = 3.
- Launch on a tick, then 1 tick → ball_x = 330, ball_y = 398, ball_active = 1.
- In PLAY with dy = -1, collide_block = 0x006 on one tick → block_alive = 0x3FD, score = 1, dy = +1 (ball_y increases by 2 next tick). Repeat with bit1 already dead → bit2 is cleared.
- collide_paddle = 1 while dy = +1 → dy = -1. collide_paddle = 1 while dy = -1 → no change. Paddle and block flags together → only the block is processed.
- Force ball_x = 630 with dx = +1 → dx = -1 and ball_x = 628. Ball falls to ball_y = 472 → LOST, lives = 2, back to SERVE. After the third loss → game_over = 1 and the ball is frozen.
- Clear all 10 blocks → WIN with game_over = 1 and score = 10. Assert rst low mid-PLAY → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ball_physics_pkg.sv
// Shared game constants and state encoding for the collision, physics and render stages.
package ball_physics_pkg;

  typedef enum logic [2:0] {
    StServe,
    StPlay,
    StLost,
    StOver,
    StWin
  } state_e;

  localparam logic [9:0]  SCREEN_W     = 10'd640;
  localparam logic [9:0]  SCREEN_H     = 10'd480;
  localparam logic [9:0]  BALL_SIZE    = 10'd8;
  localparam logic [9:0]  SPEED        = 10'd2;
  localparam logic [9:0]  START_X      = 10'd316;
  localparam logic [9:0]  START_Y      = 10'd400;
  localparam logic [1:0]  START_LIVES  = 2'd3;
  localparam int unsigned NUM_BLOCKS   = 10;

  // Ball sits centred over a 64-pixel paddle while waiting to be served.
  localparam logic [9:0]  SERVE_OFFSET = 10'd28;

endpackage

// File: rtl/block_hit_select.sv
// Picks the lowest-indexed live block that the ball overlaps; one-hot clear mask.
module block_hit_select #(
  parameter int unsigned NumBlocks = 10
) (
  input  logic [NumBlocks-1:0] i_collide,
  input  logic [NumBlocks-1:0] i_alive,
  output logic                 o_hit_valid,
  output logic [NumBlocks-1:0] o_clear_mask
);

  logic [NumBlocks-1:0] w_cand;

  assign w_cand       = i_collide & i_alive;
  assign o_hit_valid  = |w_cand;
  // Two's-complement trick isolates the lowest set bit.
  assign o_clear_mask = w_cand & (~w_cand + {{(NumBlocks-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ball_physics.sv
// Per-frame game-state update: ball motion, block/paddle/wall reflection, score, lives.
module ball_physics
  import ball_physics_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_frame_tick,
  input  logic                  i_launch,
  input  logic                  i_collide_paddle,
  input  logic [NUM_BLOCKS-1:0] i_collide_block,
  input  logic [9:0]            i_paddle_x,
  output logic [9:0]            o_ball_x,
  output logic [9:0]            o_ball_y,
  output logic [NUM_BLOCKS-1:0] o_block_alive,
  output logic [7:0]            o_score,
  output logic [1:0]            o_lives,
  output logic                  o_game_over,
  output logic                  o_ball_active
);

  state_e                r_state, w_state_d;
  logic [9:0]            r_ball_x, w_ball_x_d;
  logic [9:0]            r_ball_y, w_ball_y_d;
  logic                  r_dx_pos, w_dx_pos_d;
  logic                  r_dy_down, w_dy_down_d;
  logic [NUM_BLOCKS-1:0] r_alive, w_alive_d;
  logic [7:0]            r_score, w_score_d;
  logic [1:0]            r_lives, w_lives_d;

  logic                  w_hit_valid;
  logic [NUM_BLOCKS-1:0] w_clear_mask;
  logic [10:0]           w_x_right;
  logic [10:0]           w_y_bottom;
  logic [1:0]            w_lives_dec;

  block_hit_select #(
    .NumBlocks(NUM_BLOCKS)
  ) u_block_hit_select (
    .i_collide   (i_collide_block),
    .i_alive     (r_alive),
    .o_hit_valid (w_hit_valid),
    .o_clear_mask(w_clear_mask)
  );

  assign w_x_right   = {1'b0, r_ball_x} + {1'b0, BALL_SIZE};
  assign w_y_bottom  = {1'b0, r_ball_y} + {1'b0, BALL_SIZE};
  assign w_lives_dec = r_lives - 2'd1;

  always_comb begin
    w_state_d   = r_state;
    w_ball_x_d  = r_ball_x;
    w_ball_y_d  = r_ball_y;
    w_dx_pos_d  = r_dx_pos;
    w_dy_down_d = r_dy_down;
    w_alive_d   = r_alive;
    w_score_d   = r_score;
    w_lives_d   = r_lives;

    if (i_frame_tick) begin
      case (r_state)
        StServe: begin
          w_ball_x_d  = i_paddle_x + SERVE_OFFSET;
          w_ball_y_d  = START_Y;
          w_dx_pos_d  = 1'b1;
          w_dy_down_d = 1'b0;
          if (i_launch) w_state_d = StPlay;
        end

        StPlay: begin
          if (w_hit_valid) begin
            w_alive_d   = r_alive & ~w_clear_mask;
            w_score_d   = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
            w_dy_down_d = ~r_dy_down;
          end else if (i_collide_paddle && r_dy_down) begin
            w_dy_down_d = 1'b0;
          end

          // Walls use the pre-move position and take precedence over hit reflections.
          if (r_ball_x <= SPEED) w_dx_pos_d = 1'b1;
          if (w_x_right >= {1'b0, SCREEN_W - SPEED}) w_dx_pos_d = 1'b0;
          if (r_ball_y <= SPEED) w_dy_down_d = 1'b1;

          if (w_alive_d == '0) begin
            w_state_d  = StWin;
            w_ball_x_d = w_dx_pos_d ? r_ball_x + SPEED : r_ball_x - SPEED;
            w_ball_y_d = w_dy_down_d ? r_ball_y + SPEED : r_ball_y - SPEED;
          end else if (w_y_bottom >= {1'b0, SCREEN_H}) begin
            w_state_d = StLost;
          end else begin
            w_ball_x_d = w_dx_pos_d ? r_ball_x + SPEED : r_ball_x - SPEED;
            w_ball_y_d = w_dy_down_d ? r_ball_y + SPEED : r_ball_y - SPEED;
          end
        end

        StLost: begin
          w_lives_d = w_lives_dec;
          w_state_d = (w_lives_dec == 2'd0) ? StOver : StServe;
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StServe;
      r_ball_x  <= START_X;
      r_ball_y  <= START_Y;
      r_dx_pos  <= 1'b1;
      r_dy_down <= 1'b0;
      r_alive   <= '1;
      r_score   <= 8'd0;
      r_lives   <= START_LIVES;
    end else begin
      r_state   <= w_state_d;
      r_ball_x  <= w_ball_x_d;
      r_ball_y  <= w_ball_y_d;
      r_dx_pos  <= w_dx_pos_d;
      r_dy_down <= w_dy_down_d;
      r_alive   <= w_alive_d;
      r_score   <= w_score_d;
      r_lives   <= w_lives_d;
    end
  end

  assign o_ball_x      = r_ball_x;
  assign o_ball_y      = r_ball_y;
  assign o_block_alive = r_alive;
  assign o_score       = r_score;
  assign o_lives       = r_lives;
  assign o_game_over   = (r_state == StOver) || (r_state == StWin);
  assign o_ball_active = (r_state == StPlay);

endmodule

// File: tb/tb_ball_physics.sv
// Scoreboard bench for ball_physics: stimulus queues expected outputs, a monitor checks them.
module tb_ball_physics;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       launch;
  logic       collide_paddle;
  logic [9:0] collide_block;
  logic [9:0] paddle_x;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] block_alive;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic       ball_active;

  typedef struct {
    string      name;
    logic       chk;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] alive;
    logic [7:0] score;
    logic [1:0] lives;
    logic       go;
    logic       act;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic tick_q  = 1'b0;
  logic rst_chk = 1'b0;
  logic armed   = 1'b0;

  ball_physics u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_frame_tick    (frame_tick),
    .i_launch        (launch),
    .i_collide_paddle(collide_paddle),
    .i_collide_block (collide_block),
    .i_paddle_x      (paddle_x),
    .o_ball_x        (ball_x),
    .o_ball_y        (ball_y),
    .o_block_alive   (block_alive),
    .o_score         (score),
    .o_lives         (lives),
    .o_game_over     (game_over),
    .o_ball_active   (ball_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tick_q <= frame_tick;

  // Monitor: every registered tick update (or forced reset check) consumes one entry.
  always @(negedge clk) begin
    if (tick_q || rst_chk) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty: got an output update, want a queued expectation");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk) begin
          n_total++;
          if (ball_x === e.x && ball_y === e.y && block_alive === e.alive &&
              score === e.score && lives === e.lives && game_over === e.go &&
              ball_active === e.act) begin
            n_pass++;
          end else begin
            $display("FAIL %s: got x=%0d y=%0d alive=%h score=%0d lives=%0d go=%b act=%b, want x=%0d y=%0d alive=%h score=%0d lives=%0d go=%b act=%b",
                     e.name, ball_x, ball_y, block_alive, score, lives, game_over, ball_active,
                     e.x, e.y, e.alive, e.score, e.lives, e.go, e.act);
          end
        end
      end
    end
  end

  task automatic push(input string nm, input logic [9:0] x, input logic [9:0] y,
                      input logic [9:0] alive, input logic [7:0] sc, input logic [1:0] lv,
                      input logic go, input logic act);
    exp_t e;
    e.name = nm; e.chk = 1'b1; e.x = x; e.y = y; e.alive = alive;
    e.score = sc; e.lives = lv; e.go = go; e.act = act;
    q.push_back(e);
    armed = 1'b1;
  endtask

  task automatic tick(input logic ln, input logic pd, input logic [9:0] blk,
                      input logic [9:0] px);
    if (!armed) begin
      exp_t e;
      e.name = "unchecked"; e.chk = 1'b0; e.x = '0; e.y = '0; e.alive = '0;
      e.score = '0; e.lives = '0; e.go = 1'b0; e.act = 1'b0;
      q.push_back(e);
    end
    armed = 1'b0;
    @(posedge clk);
    #1;
    launch = ln; collide_paddle = pd; collide_block = blk; paddle_x = px; frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; launch = 1'b0; collide_paddle = 1'b0; collide_block = '0;
  endtask

  task automatic async_reset_check(input string nm);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push(nm, 10'd316, 10'd400, 10'h3FF, 8'd0, 2'd3, 1'b0, 1'b0);
    armed = 1'b0;
    rst_chk = 1'b1;
    @(negedge clk);
    #1;
    rst_chk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; launch = 1'b0; collide_paddle = 1'b0;
    collide_block = '0; paddle_x = 10'd300;
    repeat (2) @(posedge clk);
    async_reset_check("reset_state");

    for (int i = 0; i < 3; i++) begin
      push("serve_follow", 10'd328, 10'd400, 10'h3FF, 8'd0, 2'd3, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 10'h000, 10'd300);
    end
    // Launch held between ticks must be ignored.
    @(posedge clk); #1 launch = 1'b1;
    repeat (3) @(posedge clk);
    #1 launch = 1'b0;
    push("launch_off_tick", 10'd328, 10'd400, 10'h3FF, 8'd0, 2'd3, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 10'h000, 10'd300);

    push("launch", 10'd328, 10'd400, 10'h3FF, 8'd0, 2'd3, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 10'h000, 10'd300);
    push("first_move", 10'd330, 10'd398, 10'h3FF, 8'd0, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h000, 10'd300);
    push("block_hit", 10'd332, 10'd400, 10'h3FD, 8'd1, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h006, 10'd300);
    push("dead_skip", 10'd334, 10'd398, 10'h3F9, 8'd2, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h006, 10'd300);
    push("paddle_up_ignored", 10'd336, 10'd396, 10'h3F9, 8'd2, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 10'h000, 10'd300);
    push("block_bit0", 10'd338, 10'd398, 10'h3F8, 8'd3, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h001, 10'd300);
    push("paddle_down", 10'd340, 10'd396, 10'h3F8, 8'd3, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 10'h000, 10'd300);
    push("block_over_paddle", 10'd342, 10'd398, 10'h3F0, 8'd4, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 10'h008, 10'd300);
    push("dead_no_reflect", 10'd344, 10'd400, 10'h3F0, 8'd4, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h002, 10'd300);

    for (int i = 0; i < 35; i++) tick(1'b0, 1'b0, 10'h000, 10'd300);
    push("fall_bottom1", 10'd416, 10'd472, 10'h3F0, 8'd4, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h000, 10'd300);
    push("lost1", 10'd416, 10'd472, 10'h3F0, 8'd4, 2'd3, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 10'h000, 10'd300);
    push("serve_lives2", 10'd416, 10'd472, 10'h3F0, 8'd4, 2'd2, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 10'h000, 10'd300);

    push("serve_edge", 10'd630, 10'd400, 10'h3F0, 8'd4, 2'd2, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 10'h000, 10'd602);
    push("wall_right", 10'd628, 10'd398, 10'h3F0, 8'd4, 2'd2, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h000, 10'd602);
    push("turn_down2", 10'd626, 10'd400, 10'h3E0, 8'd5, 2'd2, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h010, 10'd602);
    for (int i = 0; i < 35; i++) tick(1'b0, 1'b0, 10'h000, 10'd602);
    push("fall_bottom2", 10'd554, 10'd472, 10'h3E0, 8'd5, 2'd2, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h000, 10'd602);
    push("lost2", 10'd554, 10'd472, 10'h3E0, 8'd5, 2'd2, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 10'h000, 10'd602);
    push("serve_lives1", 10'd554, 10'd472, 10'h3E0, 8'd5, 2'd1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 10'h000, 10'd602);

    push("launch3", 10'd328, 10'd400, 10'h3E0, 8'd5, 2'd1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 10'h000, 10'd300);
    push("turn_down3", 10'd330, 10'd402, 10'h3C0, 8'd6, 2'd1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h020, 10'd300);
    for (int i = 0; i < 34; i++) tick(1'b0, 1'b0, 10'h000, 10'd300);
    push("fall_bottom3", 10'd400, 10'd472, 10'h3C0, 8'd6, 2'd1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h000, 10'd300);
    push("lost3", 10'd400, 10'd472, 10'h3C0, 8'd6, 2'd1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 10'h000, 10'd300);
    push("game_over", 10'd400, 10'd472, 10'h3C0, 8'd6, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 10'h000, 10'd300);
    push("over_frozen", 10'd400, 10'd472, 10'h3C0, 8'd6, 2'd0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 10'h040, 10'd300);

    async_reset_check("reset_from_over");
    push("relaunch", 10'd328, 10'd400, 10'h3FF, 8'd0, 2'd3, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 10'h000, 10'd300);
    push("relaunch_move", 10'd330, 10'd398, 10'h3FF, 8'd0, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'h000, 10'd300);
    async_reset_check("reset_mid_play");

    push("win_launch", 10'd328, 10'd400, 10'h3FF, 8'd0, 2'd3, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 10'h000, 10'd300);
    for (int k = 1; k <= 10; k++) begin
      if (k == 1)
        push("clear_one", 10'd330, 10'd402, 10'h3FE, 8'd1, 2'd3, 1'b0, 1'b1);
      else if (k == 5)
        push("clear_five", 10'd338, 10'd402, 10'h3E0, 8'd5, 2'd3, 1'b0, 1'b1);
      else if (k == 10)
        push("win", 10'd348, 10'd400, 10'h000, 8'd10, 2'd3, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 10'h3FF, 10'd300);
    end
    push("win_frozen", 10'd348, 10'd400, 10'h000, 8'd10, 2'd3, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 10'h3FF, 10'd300);

    repeat (4) @(posedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
